// File: rtl/fetch_pc_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit_if
// Description : Signal bundle for the LC-3b instruction-fetch stage. It carries
//               the branch-prediction lookup, the I-cache read/resp handshake,
//               the IF/ID output slot and the branch-resolution feedback.
//               master : the fetch unit itself
//               slave  : everything around it (predictor, I-cache, IF/ID,
//                        resolving stage)
// Revision    : 1.0  initial release
// ============================================================================
interface fetch_pc_unit_if;
    // branch prediction lookup
    logic        take_branch;
    logic [15:0] to_target;
    logic [15:0] fetch_pc;
    // I-cache
    logic        icache_read;
    logic [15:0] icache_addr;
    logic        icache_resp;
    logic [15:0] icache_rdata;
    // IF/ID output slot
    logic        id_ready;
    logic        if_valid;
    logic [15:0] if_pc;
    logic [15:0] if_ir;
    logic        if_pred_taken;
    // branch resolution / flush
    logic        resolve_valid;
    logic [15:0] resolve_pc;
    logic        resolve_taken;
    logic [15:0] resolve_target;
    logic        resolve_pred_taken;
    logic        if_flush;

    modport master (
        input  take_branch, to_target, icache_resp, icache_rdata, id_ready,
               resolve_valid, resolve_pc, resolve_taken, resolve_target,
               resolve_pred_taken,
        output fetch_pc, icache_read, icache_addr, if_valid, if_pc, if_ir,
               if_pred_taken, if_flush
    );

    modport slave (
        output take_branch, to_target, icache_resp, icache_rdata, id_ready,
               resolve_valid, resolve_pc, resolve_taken, resolve_target,
               resolve_pred_taken,
        input  fetch_pc, icache_read, icache_addr, if_valid, if_pc, if_ir,
               if_pred_taken, if_flush
    );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit
// Description : LC-3b instruction-fetch stage. Owns the fetch PC, follows the
//               branch predictor's take_branch/to_target, runs the I-cache
//               read/resp handshake and hands {pc, ir, predicted-taken} to
//               IF/ID through an output slot plus a one-entry hold buffer.
//               A mispredict from a later stage squashes and redirects.
// Ports       : clk   - pipeline clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - fetch_pc_unit_if.master (predictor, I-cache, IF/ID,
//                       branch resolution, if_flush)
// Revision    : 1.0  initial release
// ============================================================================
module fetch_pc_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  wire              clk,
    input  wire              rst_n,
    fetch_pc_unit_if.master  bus
);

    localparam logic [15:0] c_PC_MASK  = 16'hFFFE;
    localparam logic [15:0] c_RESET_PC = RESET_PC & c_PC_MASK;

    // FETCH : read outstanding on fetch_pc
    // HOLD  : output slot and hold buffer both full, no read
    // DRAIN : waiting for a response that belongs to a squashed fetch
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      r_state,     w_state_nx;
    logic [15:0] r_pc,        w_pc_nx;
    logic [15:0] r_pend_pc,   w_pend_nx;
    logic        r_out_valid, w_out_valid_nx;
    logic [15:0] r_out_pc,    w_out_pc_nx;
    logic [15:0] r_out_ir,    w_out_ir_nx;
    logic        r_out_pt,    w_out_pt_nx;
    logic [15:0] r_hold_pc,   w_hold_pc_nx;
    logic [15:0] r_hold_ir,   w_hold_ir_nx;
    logic        r_hold_pt,   w_hold_pt_nx;

    logic        w_redirect;
    logic [15:0] w_redirect_pc;
    logic [15:0] w_next_pc;
    logic        w_consume;
    logic        w_slot_free;

    assign w_redirect    = bus.resolve_valid && (bus.resolve_taken != bus.resolve_pred_taken);
    assign w_redirect_pc = (bus.resolve_taken ? bus.resolve_target
                                              : bus.resolve_pc + 16'd2) & c_PC_MASK;
    assign w_next_pc     = (bus.take_branch ? bus.to_target : r_pc + 16'd2) & c_PC_MASK;
    assign w_consume     = r_out_valid && bus.id_ready;
    assign w_slot_free   = !r_out_valid || w_consume;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_pc        <= c_RESET_PC;
            r_pend_pc   <= c_RESET_PC;
            r_out_valid <= 1'b0;
            r_out_pc    <= 16'h0000;
            r_out_ir    <= 16'h0000;
            r_out_pt    <= 1'b0;
            r_hold_pc   <= 16'h0000;
            r_hold_ir   <= 16'h0000;
            r_hold_pt   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_pc        <= w_pc_nx;
            r_pend_pc   <= w_pend_nx;
            r_out_valid <= w_out_valid_nx;
            r_out_pc    <= w_out_pc_nx;
            r_out_ir    <= w_out_ir_nx;
            r_out_pt    <= w_out_pt_nx;
            r_hold_pc   <= w_hold_pc_nx;
            r_hold_ir   <= w_hold_ir_nx;
            r_hold_pt   <= w_hold_pt_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_pc_nx        = r_pc;
        w_pend_nx      = r_pend_pc;
        w_out_valid_nx = r_out_valid;
        w_out_pc_nx    = r_out_pc;
        w_out_ir_nx    = r_out_ir;
        w_out_pt_nx    = r_out_pt;
        w_hold_pc_nx   = r_hold_pc;
        w_hold_ir_nx   = r_hold_ir;
        w_hold_pt_nx   = r_hold_pt;

        case (r_state)
            S_FETCH: begin
                if (w_redirect) begin
                    w_out_valid_nx = 1'b0;
                    if (bus.icache_resp) begin
                        w_pc_nx = w_redirect_pc;
                    end else begin
                        // The read cannot be cancelled: keep the address on
                        // the bus until its response shows up, then jump.
                        w_pend_nx  = w_redirect_pc;
                        w_state_nx = S_DRAIN;
                    end
                end else if (bus.icache_resp) begin
                    if (w_slot_free) begin
                        w_out_valid_nx = 1'b1;
                        w_out_pc_nx    = r_pc;
                        w_out_ir_nx    = bus.icache_rdata;
                        w_out_pt_nx    = bus.take_branch;
                    end else begin
                        w_hold_pc_nx = r_pc;
                        w_hold_ir_nx = bus.icache_rdata;
                        w_hold_pt_nx = bus.take_branch;
                        w_state_nx   = S_HOLD;
                    end
                    w_pc_nx = w_next_pc;
                end else if (w_consume) begin
                    w_out_valid_nx = 1'b0;
                end
            end
            S_HOLD: begin
                if (w_redirect) begin
                    w_out_valid_nx = 1'b0;
                    w_pc_nx        = w_redirect_pc;
                    w_state_nx     = S_FETCH;
                end else if (bus.id_ready) begin
                    w_out_valid_nx = 1'b1;
                    w_out_pc_nx    = r_hold_pc;
                    w_out_ir_nx    = r_hold_ir;
                    w_out_pt_nx    = r_hold_pt;
                    w_state_nx     = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (w_redirect) begin
                    w_out_valid_nx = 1'b0;
                    if (bus.icache_resp) begin
                        w_pc_nx    = w_redirect_pc;
                        w_state_nx = S_FETCH;
                    end else begin
                        w_pend_nx = w_redirect_pc;
                    end
                end else if (bus.icache_resp) begin
                    w_pc_nx    = r_pend_pc;
                    w_state_nx = S_FETCH;
                end
            end
            default: begin
                w_state_nx = S_FETCH;
            end
        endcase
    end

    assign bus.fetch_pc      = r_pc;
    assign bus.icache_addr   = r_pc;
    // Gated with rst_n so no read is requested while the I-cache is in reset.
    assign bus.icache_read   = rst_n && (r_state != S_HOLD);
    assign bus.if_valid      = r_out_valid;
    assign bus.if_pc         = r_out_pc;
    assign bus.if_ir         = r_out_ir;
    assign bus.if_pred_taken = r_out_pt;
    assign bus.if_flush      = rst_n && w_redirect;

endmodule
`default_nettype wire

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage of the pipelined LC-3b; sits directly upstream of the branch prediction unit.
- Owns the fetch PC and drives it to the branch prediction unit lookup index (from_source).
- Consumes the unit's take_branch / to_target to choose the next PC, runs the I-cache read/resp handshake and delivers {pc, ir, predicted-taken} to IF/ID through a 2-entry skid.
- On a branch mispredict reported by a later stage, squashes in-flight fetches and redirects.

Parameters:
- RESET_PC, 16'h0000, PC loaded on reset.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- take_branch  in  1  prediction for the PC on fetch_pc (combinational from the branch prediction unit).
- to_target  in  16  predicted target for fetch_pc.
- fetch_pc  out  16  current fetch PC; drives the branch prediction unit from_source.
- icache_read  out  1  I-cache read request.
- icache_addr  out  16  I-cache address (equals fetch_pc).
- icache_resp  in  1  I-cache response, one cycle per read.
- icache_rdata  in  16  instruction word, valid with icache_resp.
- id_ready  in  1  IF/ID accepts the output this cycle (low = stall).
- if_valid  out  1  output holds a valid instruction.
- if_pc  out  16  PC of the output instruction.
- if_ir  out  16  output instruction word.
- if_pred_taken  out  1  take_branch sampled when the instruction was fetched.
- resolve_valid  in  1  a conditional branch resolved this cycle.
- resolve_pc  in  16  PC of the resolved branch.
- resolve_taken  in  1  actual outcome.
- resolve_target  in  16  actual taken target.
- resolve_pred_taken  in  1  prediction carried with that branch.
- if_flush  out  1  squash younger instructions in IF/ID and ID/EX.

Behaviour:
- Reset, asynchronous and active-low: state=FETCH, fetch_pc=RESET_PC, if_valid=0, hold buffer empty, icache_read=0 while rst_n is low, if_flush=0, if_pc/if_ir=0.
- redirect is combinational: resolve_valid && (resolve_taken != resolve_pred_taken).
- redirect_pc = resolve_taken ? resolve_target : resolve_pc+2.
- if_flush = redirect.
- next_pc = take_branch ? to_target : fetch_pc+2. Addition is mod 2^16, so 16'hFFFE+2 = 16'h0000. Bit 0 is forced to 0 on every PC load.
- icache_addr = fetch_pc. fetch_pc stays stable while icache_read=1 and no icache_resp has arrived.
- Output slot is consumed when if_valid && id_ready. The slot is free when !if_valid or it is being consumed.
- FETCH (icache_read=1):
  - resp, no redirect, slot free: load output {fetch_pc, rdata, take_branch}, set if_valid=1, fetch_pc<=next_pc, stay in FETCH. Result: one instruction per cycle for a 1-cycle cache.
  - resp, no redirect, slot busy: write the same tuple to the hold buffer, fetch_pc<=next_pc, go to HOLD.
  - no resp: if_valid<=0 when the slot is consumed.
- HOLD (icache_read=0): when id_ready, move the hold buffer to the output and go to FETCH.
- DRAIN (icache_read=1, address unchanged): wait for the outstanding response and discard it. Then fetch_pc<=pend_pc and go to FETCH.
- Redirect takes priority over everything else in every state:
  - clear if_valid and the hold buffer;
  - FETCH with resp this cycle: discard rdata, fetch_pc<=redirect_pc, stay in FETCH;
  - FETCH without resp: pend_pc<=redirect_pc, go to DRAIN;
  - HOLD: fetch_pc<=redirect_pc, go to FETCH;
  - DRAIN: pend_pc<=redirect_pc (latest redirect wins). If resp arrives the same cycle, go to FETCH with fetch_pc=redirect_pc.
- Redirect and id_ready high in the same cycle: the flush wins and nothing is delivered.
- Reset asserted mid-read: the outstanding response is abandoned. The I-cache is reset by the same rst_n.
- if_valid never drops without a consume or a redirect. if_pc, if_ir and if_pred_taken stay stable while if_valid && !id_ready.

Test Plan:
- Reset, sequential fetch: release rst_n, cache answers every cycle with 1-cycle latency, take_branch=0 -> icache_addr 0000,0002,0004; if_pc follows one cycle behind; if_valid=1 from cycle 2.
- Predicted taken: fetch_pc=0010 with take_branch=1 and to_target=0040 -> if_pred_taken=1 for if_pc=0010, next icache_addr=0040.
- Stall and skid: id_ready=0 for 3 cycles while fetching 0020 and 0022 -> output holds 0020, 0022 sits in hold, icache_read=0. id_ready=1 -> 0022 delivered next, then fetch resumes at 0024.
- Mispredict during outstanding read: read of 0030 pending, resolve_pc=0008, taken=1, pred=0, target=0100 -> if_flush=1 for 1 cycle, DRAIN until resp, the 0030 word is dropped, next icache_addr=0100.
- Not-taken mispredict with wrap: resolve_pc=FFFE, taken=0, pred=1 -> redirect to 0000.
- Back-to-back redirects in DRAIN (0100 then 0200) -> only 0200 is fetched; async rst_n pulse mid-DRAIN -> fetch_pc=RESET_PC, if_valid=0 immediately.
